// File: rtl/aibcr3pnr_rstseq.sv
// Reset sequencer: releases NUM_DOM domain resets in ascending order, each with a stagger and a ready/timeout handshake.
// Optional scan bypass of all domain resets via `define AIBCR3_RSTSEQ_SCAN_BYPASS_EN.
module aibcr3pnr_rstseq #(
    parameter int NUM_DOM     = 4,
    parameter int CNT_W       = 10,
    parameter int STAGGER_CYC = 16,
    parameter int TIMEOUT_CYC = 512
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               scan_mode_n,
    input  logic               rst_n_bypass,
    input  logic               seq_start,
    input  logic               seq_abort,
    input  logic [NUM_DOM-1:0] dom_ready,
    output logic [NUM_DOM-1:0] dom_rst_n,
    output logic               seq_done,
    output logic               seq_err,
    output logic [2:0]         seq_err_dom,
    output logic [2:0]         seq_state
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RELEASE  = 3'd1,
        STAGGER  = 3'd2,
        WAIT_RDY = 3'd3,
        NEXT     = 3'd4,
        DONE     = 3'd5,
        ERR      = 3'd6
    } state_t;

    localparam logic [CNT_W-1:0] STG_LAST = CNT_W'(STAGGER_CYC - 1);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [2:0]       LAST_IDX = 3'(NUM_DOM - 1);

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic [2:0]         idx, idx_nxt;
    logic [NUM_DOM-1:0] rst_q, rst_nxt;
    logic [NUM_DOM-1:0] rdy_p0, rdy_p1;
    logic [NUM_DOM-1:0] idx_mask;
    logic               rdy_cur;
    logic               scan_hold;

`ifdef AIBCR3_RSTSEQ_SCAN_BYPASS_EN
    assign scan_hold = ~scan_mode_n;
    assign dom_rst_n = scan_hold ? {NUM_DOM{rst_n_bypass}} : rst_q;
`else
    logic unused_scan;
    assign unused_scan = scan_mode_n ^ rst_n_bypass;
    assign scan_hold   = 1'b0;
    assign dom_rst_n   = rst_q;
`endif

    // Stage p0/p1: two-flop synchronizer for the asynchronous ready inputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdy_p0 <= '0;
            rdy_p1 <= '0;
        end else begin
            rdy_p0 <= dom_ready;
            rdy_p1 <= rdy_p0;
        end
    end

    // idx is 3 bits wide regardless of NUM_DOM, so decode it instead of indexing
    always_comb begin
        idx_mask = '0;
        rdy_cur  = 1'b0;
        for (int i = 0; i < NUM_DOM; i++) begin
            if (idx == 3'(i)) begin
                idx_mask[i] = 1'b1;
                rdy_cur     = rdy_p1[i];
            end
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        idx_nxt   = idx;
        rst_nxt   = rst_q;
        if (seq_abort || scan_hold) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
            idx_nxt   = '0;
            rst_nxt   = '0;
        end else if (state == IDLE) begin
            rst_nxt = '0;
            if (seq_start) state_nxt = RELEASE;
        end else if (seq_start) begin
            // Dropping seq_start freezes every in-flight state; DONE and ERR ignore it anyway
            case (state)
                RELEASE: begin
                    rst_nxt   = rst_q | idx_mask;
                    cnt_nxt   = '0;
                    state_nxt = STAGGER;
                end
                STAGGER: begin
                    if (cnt == STG_LAST) begin
                        cnt_nxt   = '0;
                        state_nxt = WAIT_RDY;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
                WAIT_RDY: begin
                    if (rdy_cur) begin
                        cnt_nxt   = '0;
                        state_nxt = NEXT;
                    end else if (cnt == TMO_LAST) begin
                        rst_nxt   = rst_q & ~idx_mask;
                        state_nxt = ERR;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
                NEXT: begin
                    if (idx == LAST_IDX) begin
                        state_nxt = DONE;
                    end else begin
                        idx_nxt   = idx + 3'd1;
                        state_nxt = RELEASE;
                    end
                end
                DONE, ERR: begin
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Stage boundary: sequencer state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            idx   <= '0;
            rst_q <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            idx   <= idx_nxt;
            rst_q <= rst_nxt;
        end
    end

    assign seq_state   = state;
    assign seq_done    = (state == DONE) && !scan_hold;
    assign seq_err     = (state == ERR) && !scan_hold;
    assign seq_err_dom = seq_err ? idx : 3'd0;

endmodule
